frame_deframer: RTL and testbench



---
 rtl/frame_deframer.sv | 210 +++++++++++++++++++++
 tb/tb_frame_deframer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_deframer.sv
// Byte-serial receive deframer: hunts for the start flag, removes escape
// stuffing, assembles FRAME_BYTES de-stuffed bytes into a wide frame vector,
// optionally checks a trailing CRC-32/MPEG-2 and hands the frame out with a
// valid/ready handshake. Malformed frames produce a one-cycle error pulse.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx_data       received byte
//   rx_valid      one-cycle strobe qualifying rx_data
//   frame         assembled frame; bit 0 is the MSB of the first byte
//   frame_valid   frame holds a complete, checked frame
//   frame_ready   sink accepts the frame this cycle
//   err_valid     one-cycle error pulse
//   err_code      error cause, qualified by err_valid
//   busy          a frame is being received
module frame_deframer #(
  parameter int unsigned FRAME_BYTES = 39,
  parameter bit          CRC_EN      = 1'b1,
  parameter logic [7:0]  FRAME_START = 8'h06,
  parameter logic [7:0]  FRAME_END   = 8'h07,
  parameter logic [7:0]  ESC_VAL     = 8'h14,
  parameter logic [7:0]  ESC_XOR     = 8'h20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [FRAME_BYTES*8-1:0] frame,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     err_valid,
  output logic [2:0]               err_code,
  output logic                     busy
);

  localparam int unsigned FW = FRAME_BYTES * 8;
  localparam int unsigned CW = $clog2(FRAME_BYTES + 1);
  localparam int unsigned BW = $clog2(FW);

  localparam logic [31:0]   CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]   CRC_POLY = 32'h04C1_1DB7;
  localparam logic [CW-1:0] LEN      = CW'(FRAME_BYTES);
  localparam logic [CW-1:0] CRC_LEN  = CW'(FRAME_BYTES - 4);

  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_OVF  = 3'd2;
  localparam logic [2:0] ERR_ESC  = 3'd3;
  localparam logic [2:0] ERR_CRC  = 3'd4;
  localparam logic [2:0] ERR_DROP = 3'd5;
  localparam logic [2:0] ERR_SYNC = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_ESC} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [FW-1:0]   shadow, shadow_nxt;
  logic [31:0]     crc, crc_nxt;
  logic [FW-1:0]   frame_nxt;
  logic            fv_nxt;
  logic            ev_nxt;
  logic [2:0]      ec_nxt;
  logic            busy_nxt;
  logic            store;
  logic [7:0]      store_byte;
  logic [BW-1:0]   base;
  logic [31:0]     crc_rx;
  logic            crc_ok;

  // Frame bit order is MSB-first, so each byte lands bit-reversed in the vector.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // One byte of CRC-32/MPEG-2, MSB first, no reflection.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign base = BW'({cnt, 3'b000});

  // Received CRC: last four stored bytes, big-endian.
  always_comb begin
    crc_rx = '0;
    for (int k = 0; k < 4; k++) begin
      crc_rx[31-8*k -: 8] = rev8(shadow[(FRAME_BYTES-4+k)*8 +: 8]);
    end
  end

  assign crc_ok = !CRC_EN || (crc == crc_rx);

  // Next-state, datapath and output decisions.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    crc_nxt    = crc;
    frame_nxt  = frame;
    fv_nxt     = frame_valid & ~frame_ready;
    ev_nxt     = 1'b0;
    ec_nxt     = err_code;
    store      = 1'b0;
    store_byte = rx_data;

    if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (rx_data == FRAME_START) begin
            state_nxt = S_RECV;
            cnt_nxt   = '0;
            crc_nxt   = CRC_INIT;
          end
        end
        S_RECV: begin
          if (rx_data == FRAME_START) begin
            ev_nxt  = 1'b1;
            ec_nxt  = ERR_SYNC;
            cnt_nxt = '0;
            crc_nxt = CRC_INIT;
          end else if (rx_data == ESC_VAL) begin
            state_nxt = S_ESC;
          end else if (rx_data == FRAME_END) begin
            state_nxt = S_IDLE;
            if (cnt != LEN) begin
              ev_nxt = 1'b1;
              ec_nxt = ERR_LEN;
            end else if (!crc_ok) begin
              ev_nxt = 1'b1;
              ec_nxt = ERR_CRC;
            end else if (frame_valid && !frame_ready) begin
              ev_nxt = 1'b1;
              ec_nxt = ERR_DROP;
            end else begin
              frame_nxt = shadow;
              fv_nxt    = 1'b1;
            end
          end else begin
            store = 1'b1;
          end
        end
        S_ESC: begin
          if (rx_data == FRAME_START) begin
            ev_nxt    = 1'b1;
            ec_nxt    = ERR_SYNC;
            state_nxt = S_RECV;
            cnt_nxt   = '0;
            crc_nxt   = CRC_INIT;
          end else if (rx_data == FRAME_END) begin
            ev_nxt    = 1'b1;
            ec_nxt    = ERR_ESC;
            state_nxt = S_IDLE;
          end else begin
            store      = 1'b1;
            store_byte = rx_data ^ ESC_XOR;
            state_nxt  = S_RECV;
          end
        end
        default: state_nxt = S_IDLE;
      endcase

      // Data byte: append to the shadow frame, or overflow.
      if (store) begin
        if (cnt < LEN) begin
          shadow_nxt[base +: 8] = rev8(store_byte);
          cnt_nxt               = cnt + CW'(1);
          if (cnt < CRC_LEN) crc_nxt = crc_byte(crc, store_byte);
        end else begin
          ev_nxt    = 1'b1;
          ec_nxt    = ERR_OVF;
          state_nxt = S_IDLE;
        end
      end
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shadow      <= '0;
      crc         <= CRC_INIT;
      frame       <= '0;
      frame_valid <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shadow      <= shadow_nxt;
      crc         <= crc_nxt;
      frame       <= frame_nxt;
      frame_valid <= fv_nxt;
      err_valid   <= ev_nxt;
      err_code    <= ec_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_frame_deframer.sv
// Self-checking bench for frame_deframer (13-byte frames, CRC enabled).
// Frames are built from payload bytes by the bench (CRC appended, stuffing
// applied); expected frames and error codes are queued per scenario and a
// negedge monitor matches every transfer and error pulse against them.
module tb_frame_deframer;

  localparam int unsigned NB = 13;
  localparam int unsigned FW = NB * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [FW-1:0] frame;
  logic          frame_valid;
  logic          frame_ready;
  logic          err_valid;
  logic [2:0]    err_code;
  logic          busy;

  frame_deframer #(
    .FRAME_BYTES(NB),
    .CRC_EN     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]    data_q[$];
  logic [2:0]    err_q[$];
  logic [FW-1:0] frm_q[$];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {d, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [FW-1:0] rev_vec(input logic [FW-1:0] v);
    logic [FW-1:0] r;
    for (int i = 0; i < FW; i++) r[FW-1-i] = v[i];
    return r;
  endfunction

  // Expected frame vector: bit k*8+i holds bit (7-i) of byte k.
  function automatic logic [FW-1:0] pack_frame();
    logic [FW-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < 8; i++) v[k*8+i] = data_q[k][7-i];
    return v;
  endfunction

  task automatic set_payload9(input logic [71:0] p);
    data_q.delete();
    for (int i = 0; i < 9; i++) data_q.push_back(p[71-8*i -: 8]);
  endtask

  task automatic add_crc();
    logic [31:0] c;
    int          n;
    c = 32'hFFFF_FFFF;
    n = data_q.size();
    for (int k = 0; k < n; k++) c = crc_step(c, data_q[k]);
    for (int k = 0; k < 4; k++) data_q.push_back(c[31-8*k -: 8]);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_body(input int lo, input int hi);
    logic [7:0] b;
    for (int k = lo; k < hi; k++) begin
      b = data_q[k];
      if (b == 8'h06 || b == 8'h07 || b == 8'h14) begin
        send(8'h14);
        send(b ^ 8'h20);
      end else begin
        send(b);
      end
    end
  endtask

  task automatic send_frame();
    send(8'h06);
    send_body(0, data_q.size());
    send(8'h07);
  endtask

  // Monitor: error pulses, transfers and held-frame stability.
  logic          hold_prev = 1'b0;
  logic [FW-1:0] frame_prev = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", FW'(frame_valid), FW'(1));
        chk("hold_frame", frame, frame_prev);
      end
      if (err_valid) begin
        if (err_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_err: got code %0d expected no error", err_code);
        end else begin
          chk("err_code", FW'(err_code), FW'(err_q.pop_front()));
        end
      end
      if (frame_valid && frame_ready) begin
        if (frm_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: got %h expected no transfer", frame);
        end else begin
          chk("xfer_frame", frame, frm_q.pop_front());
        end
      end
      hold_prev  = frame_valid && !frame_ready;
      frame_prev = frame;
    end
  end

  logic [FW-1:0] exp_a;

  initial begin
    rst         = 1'b1;
    rx_data     = '0;
    rx_valid    = 1'b0;
    frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_frame", frame, '0);
    chk("rst_fv", FW'(frame_valid), FW'(0));
    chk("rst_ev", FW'(err_valid), FW'(0));
    chk("rst_ec", FW'(err_code), FW'(0));
    chk("rst_busy", FW'(busy), FW'(0));

    // Pin the model against known values
    set_payload9(72'h313233343536373839);
    add_crc();
    chk("model_crc", FW'({data_q[9], data_q[10], data_q[11], data_q[12]}), FW'(32'h0376E6E7));
    chk("model_vec", rev_vec(pack_frame()), 104'h313233343536373839_0376E6E7);

    // Good frame, ready high
    frm_q.push_back(pack_frame());
    send(8'h06);
    chk("busy_recv", FW'(busy), FW'(1));
    send_body(0, 13);
    chk("fv_before_end", FW'(frame_valid), FW'(0));
    send(8'h07);
    chk("fv_after_end", FW'(frame_valid), FW'(1));
    chk("frame_literal", rev_vec(frame), 104'h313233343536373839_0376E6E7);
    chk("good_no_err", FW'(err_valid), FW'(0));
    chk("busy_idle", FW'(busy), FW'(0));
    idle(1);
    chk("fv_cleared", FW'(frame_valid), FW'(0));

    // Escaped 0x06 in the payload
    set_payload9(72'h313233340636373839);
    add_crc();
    frm_q.push_back(pack_frame());
    send_frame();
    chk("esc06_byte4", FW'(rev8(frame[32 +: 8])), FW'(8'h06));
    idle(1);

    // Escaped 0x14 in the payload
    set_payload9(72'h313233341436373839);
    add_crc();
    frm_q.push_back(pack_frame());
    send_frame();
    chk("esc14_byte4", FW'(rev8(frame[32 +: 8])), FW'(8'h14));
    idle(1);

    // Bad CRC
    set_payload9(72'h313233343536373839);
    add_crc();
    data_q[12] = 8'hE6;
    err_q.push_back(3'd4);
    send_frame();
    chk("crc_ev", FW'(err_valid), FW'(1));
    chk("crc_ec", FW'(err_code), FW'(4));
    chk("crc_fv", FW'(frame_valid), FW'(0));
    idle(1);
    chk("crc_ev_pulse", FW'(err_valid), FW'(0));

    // Short frame (12 bytes)
    set_payload9(72'h313233343536373839);
    add_crc();
    void'(data_q.pop_back());
    err_q.push_back(3'd1);
    send_frame();
    chk("len_ec", FW'(err_code), FW'(1));
    chk("len_fv", FW'(frame_valid), FW'(0));
    idle(1);

    // Long frame (14 bytes): overflow on the 14th
    set_payload9(72'h313233343536373839);
    add_crc();
    data_q.push_back(8'h55);
    err_q.push_back(3'd2);
    send(8'h06);
    send_body(0, 13);
    chk("ovf_none_yet", FW'(err_valid), FW'(0));
    send_body(13, 14);
    chk("ovf_ev", FW'(err_valid), FW'(1));
    chk("ovf_ec", FW'(err_code), FW'(2));
    chk("ovf_busy", FW'(busy), FW'(0));
    send(8'h07);
    chk("ovf_end_ignored", FW'(err_valid), FW'(0));
    idle(1);

    // Resync on a second start flag, then a good frame
    set_payload9(72'h313233343536373839);
    add_crc();
    err_q.push_back(3'd6);
    frm_q.push_back(pack_frame());
    send(8'h06); send(8'h31); send(8'h32); send(8'h06);
    chk("sync_ec", FW'(err_code), FW'(6));
    chk("sync_busy", FW'(busy), FW'(1));
    send_body(0, 13);
    send(8'h07);
    chk("sync_fv", FW'(frame_valid), FW'(1));
    idle(1);

    // Escape followed by end flag
    err_q.push_back(3'd3);
    send(8'h06); send(8'h31); send(8'h14); send(8'h07);
    chk("esc_ec", FW'(err_code), FW'(3));
    chk("esc_busy", FW'(busy), FW'(0));
    idle(1);

    // Back-pressure: held frame, then drop of a second frame
    frame_ready = 1'b0;
    set_payload9(72'h313233343536373839);
    add_crc();
    exp_a = pack_frame();
    frm_q.push_back(exp_a);
    send_frame();
    chk("hold_fv", FW'(frame_valid), FW'(1));
    idle(3);
    chk("hold_frame_a", frame, exp_a);
    set_payload9(72'h414243444546474849);
    add_crc();
    err_q.push_back(3'd5);
    send_frame();
    chk("drop_ec", FW'(err_code), FW'(5));
    chk("drop_kept", frame, exp_a);
    frame_ready = 1'b1;
    idle(1);
    chk("drop_fv_cleared", FW'(frame_valid), FW'(0));
    chk("single_transfer", FW'(frm_q.size()), FW'(0));
    idle(2);

    // Reset mid-frame
    set_payload9(72'h313233343536373839);
    add_crc();
    send(8'h06);
    send_body(0, 5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_frame", frame, '0);
    chk("mid_rst_fv", FW'(frame_valid), FW'(0));
    chk("mid_rst_ev", FW'(err_valid), FW'(0));
    chk("mid_rst_ec", FW'(err_code), FW'(0));
    chk("mid_rst_busy", FW'(busy), FW'(0));
    frm_q.push_back(pack_frame());
    send_frame();
    chk("post_rst_fv", FW'(frame_valid), FW'(1));
    idle(3);

    chk("err_q_empty", FW'(err_q.size()), FW'(0));
    chk("frm_q_empty", FW'(frm_q.size()), FW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
